// File: rtl/atualiza_malha_pkg.sv
// Shared definitions for the occupancy-grid update block.
// Holds grid geometry constants, the cell/direction/FSM encodings and the
// index and neighbour helpers used by the top and its sub-module.
package malha_pkg;

    localparam int TAMANHO_MALHA     = 32'd20;
    localparam int TAMANHO_DISTANCIA = 32'd8;
    localparam int ALCANCE_MAXIMO    = 32'd15;
    localparam int NUM_CELULAS       = TAMANHO_MALHA * TAMANHO_MALHA;
    localparam int LARGURA_INDICE    = 32'd9;
    // Offsets carry one spare bit so edge tests never overflow
    localparam int LARGURA_PASSO     = TAMANHO_DISTANCIA + 32'd1;

    localparam logic [TAMANHO_DISTANCIA-1:0] LIMITE_COORD = TAMANHO_DISTANCIA'(TAMANHO_MALHA);
    localparam logic [TAMANHO_DISTANCIA-1:0] ALCANCE      = TAMANHO_DISTANCIA'(ALCANCE_MAXIMO);
    localparam logic [LARGURA_PASSO-1:0]     ULTIMA_COORD = LARGURA_PASSO'(TAMANHO_MALHA - 32'd1);

    typedef enum logic [1:0] {
        DESCONHECIDO = 2'b00,
        LIVRE        = 2'b01,
        OCUPADO      = 2'b10,
        FRONTEIRA    = 2'b11
    } celula_t;

    typedef enum logic [1:0] {
        MAIS_X  = 2'b00,
        MENOS_X = 2'b01,
        MAIS_Y  = 2'b10,
        MENOS_Y = 2'b11
    } direcao_t;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        RAIO      = 2'b01,
        VARRER    = 2'b10,
        SINALIZAR = 2'b11
    } estado_t;

    // Linear cell index: x + y*TamanhoMalha
    function automatic logic [LARGURA_INDICE-1:0] indice_celula(
        input logic [LARGURA_PASSO-1:0] x,
        input logic [LARGURA_PASSO-1:0] y
    );
        return LARGURA_INDICE'(x + y * LARGURA_PASSO'(TAMANHO_MALHA));
    endfunction

    // True when the robot cell is already the last in-grid cell along d
    function automatic logic na_borda(
        input logic [TAMANHO_DISTANCIA-1:0] x,
        input logic [TAMANHO_DISTANCIA-1:0] y,
        input direcao_t                     d
    );
        logic res;
        case (d)
            MAIS_X:  res = ({1'b0, x} == ULTIMA_COORD);
            MENOS_X: res = (x == 8'd0);
            MAIS_Y:  res = ({1'b0, y} == ULTIMA_COORD);
            MENOS_Y: res = (y == 8'd0);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // True when any in-grid 4-neighbour of (x,y) is still unknown
    function automatic logic tem_vizinho_desconhecido(
        input logic [2*NUM_CELULAS-1:0] m,
        input logic [LARGURA_PASSO-1:0] x,
        input logic [LARGURA_PASSO-1:0] y
    );
        logic res;
        res = 1'b0;
        if (x != 9'd0) begin
            res = res | (m[{indice_celula(x - 9'd1, y), 1'b0} +: 2] == DESCONHECIDO);
        end else begin
            res = res;
        end
        if (x != ULTIMA_COORD) begin
            res = res | (m[{indice_celula(x + 9'd1, y), 1'b0} +: 2] == DESCONHECIDO);
        end else begin
            res = res;
        end
        if (y != 9'd0) begin
            res = res | (m[{indice_celula(x, y - 9'd1), 1'b0} +: 2] == DESCONHECIDO);
        end else begin
            res = res;
        end
        if (y != ULTIMA_COORD) begin
            res = res | (m[{indice_celula(x, y + 9'd1), 1'b0} +: 2] == DESCONHECIDO);
        end else begin
            res = res;
        end
        return res;
    endfunction

endpackage

// File: rtl/atualiza_malha_if.sv
// Measurement handshake and map output bundle of atualiza_malha.
// master: measurement producer / map consumer (drives the measurement)
// slave : atualiza_malha (drives ocupado, novoDado, medidaDescartada, malha)
interface atualiza_malha_if;
    import malha_pkg::*;

    logic [TAMANHO_DISTANCIA-1:0] posicaoAtualnoEixoX;
    logic [TAMANHO_DISTANCIA-1:0] posicaoAtualnoEixoY;
    logic [1:0]                   direcao;
    logic [TAMANHO_DISTANCIA-1:0] distanciaMedida;
    logic                         medidaValida;
    logic                         ocupado;
    logic                         novoDado;
    logic                         medidaDescartada;
    logic [2*NUM_CELULAS-1:0]     malha;

    modport master (
        output posicaoAtualnoEixoX, posicaoAtualnoEixoY, direcao,
               distanciaMedida, medidaValida,
        input  ocupado, novoDado, medidaDescartada, malha
    );

    modport slave (
        input  posicaoAtualnoEixoX, posicaoAtualnoEixoY, direcao,
               distanciaMedida, medidaValida,
        output ocupado, novoDado, medidaDescartada, malha
    );
endinterface

// File: rtl/atualiza_malha_passo_raio.sv
// Ray step geometry: cell reached k steps from the origin along a direction.
// i_origem_x/y : robot cell
// i_direcao    : ray direction
// i_passo      : step k (>= 1 while casting)
// o_alvo_x/y   : target cell, one spare bit wide
// o_ultimo     : target is the last in-grid cell in this direction
module passo_raio
    import malha_pkg::*;
(
    input  logic [TAMANHO_DISTANCIA-1:0] i_origem_x,
    input  logic [TAMANHO_DISTANCIA-1:0] i_origem_y,
    input  direcao_t                     i_direcao,
    input  logic [TAMANHO_DISTANCIA-1:0] i_passo,
    output logic [LARGURA_PASSO-1:0]     o_alvo_x,
    output logic [LARGURA_PASSO-1:0]     o_alvo_y,
    output logic                         o_ultimo
);

    logic [LARGURA_PASSO-1:0] w_ox;
    logic [LARGURA_PASSO-1:0] w_oy;
    logic [LARGURA_PASSO-1:0] w_k;

    assign w_ox = {1'b0, i_origem_x};
    assign w_oy = {1'b0, i_origem_y};
    assign w_k  = {1'b0, i_passo};

    // Offset the origin and flag the grid edge in the ray direction
    always_comb begin
        o_alvo_x = w_ox;
        o_alvo_y = w_oy;
        o_ultimo = 1'b0;
        case (i_direcao)
            MAIS_X: begin
                o_alvo_x = w_ox + w_k;
                o_ultimo = (o_alvo_x == ULTIMA_COORD);
            end
            MENOS_X: begin
                o_alvo_x = w_ox - w_k;
                o_ultimo = (o_alvo_x == 9'd0);
            end
            MAIS_Y: begin
                o_alvo_y = w_oy + w_k;
                o_ultimo = (o_alvo_y == ULTIMA_COORD);
            end
            MENOS_Y: begin
                o_alvo_y = w_oy - w_k;
                o_ultimo = (o_alvo_y == 9'd0);
            end
            default: begin
                o_ultimo = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/atualiza_malha.sv
// Occupancy-grid updater: ray-casts one range measurement into the grid,
// then sweeps every cell to relabel free/frontier, then pulses novoDado.
// clock : rising-edge clock
// reset : asynchronous active-low reset, clears the grid
// bus   : measurement handshake in, ocupado/novoDado/medidaDescartada/malha out
module atualiza_malha
    import malha_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    atualiza_malha_if.slave bus
);

    estado_t                      r_estado;
    estado_t                      w_prox_estado;
    logic [TAMANHO_DISTANCIA-1:0] r_ox;
    logic [TAMANHO_DISTANCIA-1:0] r_oy;
    direcao_t                     r_dir;
    logic [TAMANHO_DISTANCIA-1:0] r_comprimento;
    logic                         r_alvo_ocupado;
    logic [TAMANHO_DISTANCIA-1:0] r_passo;
    logic [LARGURA_PASSO-1:0]     r_vx;
    logic [LARGURA_PASSO-1:0]     r_vy;
    logic [2*NUM_CELULAS-1:0]     r_malha;
    logic                         r_ocupado;
    logic                         r_novo;
    logic                         r_descartada;

    logic [TAMANHO_DISTANCIA-1:0] w_comprimento_in;
    logic                         w_alvo_in;
    logic                         w_fora;
    logic                         w_aceita;
    logic                         w_descarta;
    logic                         w_escreve;
    logic [LARGURA_INDICE-1:0]    w_indice_esc;
    celula_t                      w_valor_esc;
    logic [LARGURA_PASSO-1:0]     w_alvo_x;
    logic [LARGURA_PASSO-1:0]     w_alvo_y;
    logic                         w_ultimo;
    logic [LARGURA_INDICE-1:0]    w_indice_varre;
    logic [1:0]                   w_cel_varre;
    logic                         w_fim_varre;

    passo_raio u_passo_raio (
        .i_origem_x (r_ox),
        .i_origem_y (r_oy),
        .i_direcao  (r_dir),
        .i_passo    (r_passo),
        .o_alvo_x   (w_alvo_x),
        .o_alvo_y   (w_alvo_y),
        .o_ultimo   (w_ultimo)
    );

    assign w_fora = (bus.posicaoAtualnoEixoX >= LIMITE_COORD) ||
                    (bus.posicaoAtualnoEixoY >= LIMITE_COORD);

    assign w_indice_varre = indice_celula(r_vx, r_vy);
    assign w_cel_varre    = r_malha[{w_indice_varre, 1'b0} +: 2];
    assign w_fim_varre    = (r_vx == ULTIMA_COORD) && (r_vy == ULTIMA_COORD);

    // Ray length and hit flag of the incoming measurement; no echo or a
    // reading beyond range casts a full-range free ray
    always_comb begin
        if ((bus.distanciaMedida != 8'd0) && (bus.distanciaMedida <= ALCANCE)) begin
            w_alvo_in        = 1'b1;
            w_comprimento_in = bus.distanciaMedida;
        end else begin
            w_alvo_in        = 1'b0;
            w_comprimento_in = ALCANCE;
        end
    end

    // Next state and the single grid write performed this cycle
    always_comb begin
        w_prox_estado = r_estado;
        w_aceita      = 1'b0;
        w_descarta    = 1'b0;
        w_escreve     = 1'b0;
        w_indice_esc  = 9'd0;
        w_valor_esc   = DESCONHECIDO;
        case (r_estado)
            IDLE: begin
                if (bus.medidaValida) begin
                    if (w_fora) begin
                        w_descarta = 1'b1;
                    end else begin
                        w_aceita     = 1'b1;
                        w_escreve    = 1'b1;
                        w_indice_esc = indice_celula({1'b0, bus.posicaoAtualnoEixoX},
                                                     {1'b0, bus.posicaoAtualnoEixoY});
                        w_valor_esc  = LIVRE;
                        // Facing straight out of the grid: nothing to cast
                        if (na_borda(bus.posicaoAtualnoEixoX, bus.posicaoAtualnoEixoY,
                                     direcao_t'(bus.direcao))) begin
                            w_prox_estado = VARRER;
                        end else begin
                            w_prox_estado = RAIO;
                        end
                    end
                end else begin
                    w_prox_estado = IDLE;
                end
            end
            RAIO: begin
                w_escreve    = 1'b1;
                w_indice_esc = indice_celula(w_alvo_x, w_alvo_y);
                if ((r_passo == r_comprimento) && r_alvo_ocupado) begin
                    w_valor_esc = OCUPADO;
                end else begin
                    w_valor_esc = LIVRE;
                end
                if ((r_passo == r_comprimento) || w_ultimo) begin
                    w_prox_estado = VARRER;
                end else begin
                    w_prox_estado = RAIO;
                end
            end
            VARRER: begin
                // Only known-free cells are relabelled; 00 and 10 never change
                if ((w_cel_varre == LIVRE) || (w_cel_varre == FRONTEIRA)) begin
                    w_escreve    = 1'b1;
                    w_indice_esc = w_indice_varre;
                    if (tem_vizinho_desconhecido(r_malha, r_vx, r_vy)) begin
                        w_valor_esc = FRONTEIRA;
                    end else begin
                        w_valor_esc = LIVRE;
                    end
                end else begin
                    w_escreve = 1'b0;
                end
                if (w_fim_varre) begin
                    w_prox_estado = SINALIZAR;
                end else begin
                    w_prox_estado = VARRER;
                end
            end
            SINALIZAR: begin
                w_prox_estado = IDLE;
            end
            default: begin
                w_prox_estado = IDLE;
            end
        endcase
    end

    // FSM state, captured measurement, ray step and sweep position
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado       <= IDLE;
            r_ox           <= 8'd0;
            r_oy           <= 8'd0;
            r_dir          <= MAIS_X;
            r_comprimento  <= 8'd0;
            r_alvo_ocupado <= 1'b0;
            r_passo        <= 8'd0;
            r_vx           <= 9'd0;
            r_vy           <= 9'd0;
        end else begin
            r_estado <= w_prox_estado;
            if (w_aceita) begin
                r_ox           <= bus.posicaoAtualnoEixoX;
                r_oy           <= bus.posicaoAtualnoEixoY;
                r_dir          <= direcao_t'(bus.direcao);
                r_comprimento  <= w_comprimento_in;
                r_alvo_ocupado <= w_alvo_in;
                r_passo        <= 8'd1;
                r_vx           <= 9'd0;
                r_vy           <= 9'd0;
            end else if (r_estado == RAIO) begin
                r_passo <= r_passo + 8'd1;
            end else if (r_estado == VARRER) begin
                if (r_vx == ULTIMA_COORD) begin
                    r_vx <= 9'd0;
                    r_vy <= r_vy + 9'd1;
                end else begin
                    r_vx <= r_vx + 9'd1;
                end
            end else begin
                r_passo <= r_passo;
            end
        end
    end

    // Grid storage, one 2-bit cell written per cycle at most
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_malha <= '0;
        end else if (w_escreve) begin
            r_malha[{w_indice_esc, 1'b0} +: 2] <= w_valor_esc;
        end else begin
            r_malha <= r_malha;
        end
    end

    // Registered status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ocupado    <= 1'b0;
            r_novo       <= 1'b0;
            r_descartada <= 1'b0;
        end else begin
            r_ocupado    <= (w_prox_estado != IDLE);
            r_novo       <= (w_prox_estado == SINALIZAR);
            r_descartada <= w_descarta;
        end
    end

    assign bus.ocupado          = r_ocupado;
    assign bus.novoDado         = r_novo;
    assign bus.medidaDescartada = r_descartada;
    assign bus.malha            = r_malha;

endmodule

// File: tb/tb_atualiza_malha.sv
// Directed self-checking bench for atualiza_malha.
module tb_atualiza_malha;
    import malha_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    atualiza_malha_if bus();

    atualiza_malha dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [1:0] cel(input int x, input int y);
        return bus.malha[2*(x + y*20) +: 2];
    endfunction

    function automatic int conta(input logic [1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 400; i++) begin
            if (bus.malha[2*i +: 2] == v) c++;
        end
        return c;
    endfunction

    // Present one measurement for one cycle; returns in the cycle after acceptance
    task automatic enviar(input int x, input int y, input int dir, input int d);
        @(negedge clock);
        bus.posicaoAtualnoEixoX = 8'(x);
        bus.posicaoAtualnoEixoY = 8'(y);
        bus.direcao             = 2'(dir);
        bus.distanciaMedida     = 8'(d);
        bus.medidaValida        = 1'b1;
        @(negedge clock);
        bus.medidaValida        = 1'b0;
    endtask

    // Wait (bounded) for novoDado; lat counts cycles after the acceptance cycle
    task automatic esperar_novo(output int lat, output logic oc_pulso,
                                output logic novo_dep, output logic oc_dep);
        lat = -1; oc_pulso = 1'b0; novo_dep = 1'b1; oc_dep = 1'b1;
        for (int n = 1; n <= 3000; n++) begin
            if (bus.novoDado === 1'b1) begin
                lat = n;
                break;
            end
            @(negedge clock);
        end
        oc_pulso = bus.ocupado;
        @(negedge clock);
        novo_dep = bus.novoDado;
        oc_dep   = bus.ocupado;
    endtask

    task automatic test_reset;
        bus.posicaoAtualnoEixoX = 8'd0;
        bus.posicaoAtualnoEixoY = 8'd0;
        bus.direcao             = 2'd0;
        bus.distanciaMedida     = 8'd0;
        bus.medidaValida        = 1'b0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++; if (bus.malha !== '0) begin n_fail++; $display("FAIL reset_malha: nonzero cells %0d, required 0", 400 - conta(2'b00)); end
        n_checks++; if (bus.ocupado !== 1'b0) begin n_fail++; $display("FAIL reset_ocupado: got %b required 0", bus.ocupado); end
        n_checks++; if (bus.novoDado !== 1'b0) begin n_fail++; $display("FAIL reset_novo: got %b required 0", bus.novoDado); end
        n_checks++; if (bus.medidaDescartada !== 1'b0) begin n_fail++; $display("FAIL reset_desc: got %b required 0", bus.medidaDescartada); end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++; if (bus.ocupado !== 1'b0) begin n_fail++; $display("FAIL idle_ocupado: got %b required 0", bus.ocupado); end
    endtask

    task automatic test_reset_meio_raio;
        int pulsos;
        enviar(5, 5, 0, 8);
        repeat (2) @(negedge clock);
        n_checks++; if (cel(5,5) !== 2'b01) begin n_fail++; $display("FAIL meio_raio_robo: got %b required 01", cel(5,5)); end
        n_checks++; if (bus.ocupado !== 1'b1) begin n_fail++; $display("FAIL meio_raio_ocupado: got %b required 1", bus.ocupado); end
        reset = 1'b0;
        #1;
        n_checks++; if (bus.malha !== '0) begin n_fail++; $display("FAIL meio_raio_malha: nonzero cells %0d, required 0", 400 - conta(2'b00)); end
        n_checks++; if (bus.ocupado !== 1'b0) begin n_fail++; $display("FAIL meio_raio_oc_rst: got %b required 0", bus.ocupado); end
        @(negedge clock);
        reset = 1'b1;
        pulsos = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clock);
            if (bus.novoDado === 1'b1) pulsos++;
        end
        n_checks++; if (pulsos !== 0) begin n_fail++; $display("FAIL meio_raio_sem_novo: got %0d pulses required 0", pulsos); end
        n_checks++; if (bus.malha !== '0) begin n_fail++; $display("FAIL meio_raio_limpa: nonzero cells %0d, required 0", 400 - conta(2'b00)); end
    endtask

    task automatic test_raio_ocupado;
        int lat; logic oc, nd, od;
        enviar(5, 5, 0, 3);
        esperar_novo(lat, oc, nd, od);
        n_checks++; if (lat !== 404) begin n_fail++; $display("FAIL raio_latencia: got %0d required 404", lat); end
        n_checks++; if (oc !== 1'b1) begin n_fail++; $display("FAIL raio_ocupado_pulso: got %b required 1", oc); end
        n_checks++; if (nd !== 1'b0) begin n_fail++; $display("FAIL raio_novo_1ciclo: got %b required 0", nd); end
        n_checks++; if (od !== 1'b0) begin n_fail++; $display("FAIL raio_ocupado_cai: got %b required 0", od); end
        n_checks++; if (cel(5,5) !== 2'b11) begin n_fail++; $display("FAIL raio_5_5: got %b required 11", cel(5,5)); end
        n_checks++; if (cel(6,5) !== 2'b11) begin n_fail++; $display("FAIL raio_6_5: got %b required 11", cel(6,5)); end
        n_checks++; if (cel(7,5) !== 2'b11) begin n_fail++; $display("FAIL raio_7_5: got %b required 11", cel(7,5)); end
        n_checks++; if (cel(8,5) !== 2'b10) begin n_fail++; $display("FAIL raio_8_5: got %b required 10", cel(8,5)); end
        n_checks++; if (cel(9,5) !== 2'b00) begin n_fail++; $display("FAIL raio_9_5: got %b required 00", cel(9,5)); end
        n_checks++; if (cel(4,5) !== 2'b00) begin n_fail++; $display("FAIL raio_4_5: got %b required 00", cel(4,5)); end
    endtask

    task automatic test_borda;
        int lat; logic oc, nd, od;
        enviar(18, 10, 0, 5);
        esperar_novo(lat, oc, nd, od);
        n_checks++; if (lat !== 402) begin n_fail++; $display("FAIL borda_latencia: got %0d required 402", lat); end
        n_checks++; if (cel(19,10) !== 2'b11) begin n_fail++; $display("FAIL borda_19_10: got %b required 11", cel(19,10)); end
        n_checks++; if (cel(18,10) !== 2'b11) begin n_fail++; $display("FAIL borda_18_10: got %b required 11", cel(18,10)); end
        n_checks++; if (conta(2'b10) !== 1) begin n_fail++; $display("FAIL borda_ocupados: got %0d required 1", conta(2'b10)); end
    endtask

    task automatic test_sem_eco;
        int lat, livres; logic oc, nd, od;
        enviar(2, 2, 2, 0);
        esperar_novo(lat, oc, nd, od);
        n_checks++; if (lat !== 416) begin n_fail++; $display("FAIL sem_eco_latencia: got %0d required 416", lat); end
        livres = 0;
        for (int y = 3; y <= 17; y++) if (cel(2, y) == 2'b11) livres++;
        n_checks++; if (livres !== 15) begin n_fail++; $display("FAIL sem_eco_coluna: got %0d frontier cells required 15", livres); end
        n_checks++; if (cel(2,18) !== 2'b00) begin n_fail++; $display("FAIL sem_eco_2_18: got %b required 00", cel(2,18)); end
        n_checks++; if (cel(2,1) !== 2'b00) begin n_fail++; $display("FAIL sem_eco_2_1: got %b required 00", cel(2,1)); end
        n_checks++; if (cel(2,2) !== 2'b11) begin n_fail++; $display("FAIL sem_eco_2_2: got %b required 11", cel(2,2)); end
        n_checks++; if (conta(2'b10) !== 1) begin n_fail++; $display("FAIL sem_eco_ocupados: got %0d required 1", conta(2'b10)); end
    endtask

    task automatic test_ocupado_ignora;
        int pulsos, lat;
        enviar(15, 15, 3, 2);
        pulsos = 0; lat = -1;
        for (int n = 1; n <= 700; n++) begin
            if (bus.novoDado === 1'b1) begin
                pulsos++;
                if (lat < 0) lat = n;
            end
            if (n == 5) begin
                bus.posicaoAtualnoEixoX = 8'd0;
                bus.posicaoAtualnoEixoY = 8'd19;
                bus.direcao             = 2'd0;
                bus.distanciaMedida     = 8'd2;
                bus.medidaValida        = 1'b1;
            end else begin
                bus.medidaValida        = 1'b0;
            end
            @(negedge clock);
        end
        n_checks++; if (pulsos !== 1) begin n_fail++; $display("FAIL ignora_pulsos: got %0d required 1", pulsos); end
        n_checks++; if (lat !== 403) begin n_fail++; $display("FAIL ignora_latencia: got %0d required 403", lat); end
        n_checks++; if (cel(0,19) !== 2'b00) begin n_fail++; $display("FAIL ignora_0_19: got %b required 00", cel(0,19)); end
        n_checks++; if (cel(1,19) !== 2'b00) begin n_fail++; $display("FAIL ignora_1_19: got %b required 00", cel(1,19)); end
        n_checks++; if (cel(2,19) !== 2'b00) begin n_fail++; $display("FAIL ignora_2_19: got %b required 00", cel(2,19)); end
        n_checks++; if (cel(15,13) !== 2'b10) begin n_fail++; $display("FAIL ignora_15_13: got %b required 10", cel(15,13)); end
        n_checks++; if (cel(15,14) !== 2'b11) begin n_fail++; $display("FAIL ignora_15_14: got %b required 11", cel(15,14)); end
    endtask

    task automatic test_descarte;
        logic [2*NUM_CELULAS-1:0] snap;
        snap = bus.malha;
        enviar(25, 3, 0, 2);
        n_checks++; if (bus.medidaDescartada !== 1'b1) begin n_fail++; $display("FAIL desc_x_pulso: got %b required 1", bus.medidaDescartada); end
        n_checks++; if (bus.ocupado !== 1'b0) begin n_fail++; $display("FAIL desc_x_ocupado: got %b required 0", bus.ocupado); end
        @(negedge clock);
        n_checks++; if (bus.medidaDescartada !== 1'b0) begin n_fail++; $display("FAIL desc_x_1ciclo: got %b required 0", bus.medidaDescartada); end
        enviar(3, 20, 1, 0);
        n_checks++; if (bus.medidaDescartada !== 1'b1) begin n_fail++; $display("FAIL desc_y_pulso: got %b required 1", bus.medidaDescartada); end
        repeat (3) @(negedge clock);
        n_checks++; if (bus.ocupado !== 1'b0) begin n_fail++; $display("FAIL desc_y_ocupado: got %b required 0", bus.ocupado); end
        n_checks++; if (bus.malha !== snap) begin n_fail++; $display("FAIL desc_malha: grid changed, unknown cells %0d", conta(2'b00)); end
    endtask

    task automatic test_bloco;
        int lat, bordas; logic oc, nd, od;
        @(negedge clock); reset = 1'b0;
        @(negedge clock); reset = 1'b1;
        enviar(9, 10, 0, 2);
        esperar_novo(lat, oc, nd, od);
        n_checks++; if (lat !== 403) begin n_fail++; $display("FAIL bloco_lat0: got %0d required 403", lat); end
        enviar(9, 9, 0, 3);
        esperar_novo(lat, oc, nd, od);
        n_checks++; if (lat !== 404) begin n_fail++; $display("FAIL bloco_lat1: got %0d required 404", lat); end
        enviar(11, 9, 2, 3);
        esperar_novo(lat, oc, nd, od);
        n_checks++; if (lat !== 404) begin n_fail++; $display("FAIL bloco_lat2: got %0d required 404", lat); end
        enviar(11, 11, 1, 3);
        esperar_novo(lat, oc, nd, od);
        n_checks++; if (lat !== 404) begin n_fail++; $display("FAIL bloco_lat3: got %0d required 404", lat); end
        n_checks++; if (cel(10,10) !== 2'b01) begin n_fail++; $display("FAIL bloco_centro: got %b required 01", cel(10,10)); end
        bordas = 0;
        for (int y = 9; y <= 11; y++)
            for (int x = 9; x <= 11; x++)
                if (!(x == 10 && y == 10) && cel(x, y) == 2'b11) bordas++;
        n_checks++; if (bordas !== 8) begin n_fail++; $display("FAIL bloco_bordas: got %0d frontier cells required 8", bordas); end
        n_checks++; if (cel(11,10) !== 2'b11) begin n_fail++; $display("FAIL bloco_sobrescreve: got %b required 11", cel(11,10)); end
        n_checks++; if (conta(2'b10) !== 3) begin n_fail++; $display("FAIL bloco_ocupados: got %0d required 3", conta(2'b10)); end
        n_checks++; if (cel(12,10) !== 2'b00) begin n_fail++; $display("FAIL bloco_12_10: got %b required 00", cel(12,10)); end
    endtask

    initial begin
        test_reset();
        test_reset_meio_raio();
        test_raio_ocupado();
        test_borda();
        test_sem_eco();
        test_ocupado_ignora();
        test_descarte();
        test_bloco();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
